// File: rtl/display_scan_controller_pkg.sv
// Shared types and helpers for the multiplexed 7-segment scan controller.
package display_scan_controller_pkg;

  typedef enum logic {
    ENCENDIDO = 1'b0,
    BLANCO    = 1'b1
  } estado_t;

  localparam int unsigned ANCHO_NIBBLE = 4;
  localparam int unsigned MAX_DIGITOS  = 8;
  localparam int unsigned ANCHO_MAX    = ANCHO_NIBBLE * MAX_DIGITOS;

  // Nibble k of a packed value; k=0 is the rightmost digit.
  function automatic logic [ANCHO_NIBBLE-1:0] extraer_digito(
    input logic [ANCHO_MAX-1:0] valor,
    input logic [2:0]           k
  );
    return valor[{k, 2'b00} +: ANCHO_NIBBLE];
  endfunction

endpackage

// File: rtl/display_scan_controller_scan_divisor.sv
// Dwell/blank cycle counter: counts 0..i_Limite, then wraps with a terminal flag.
module display_scan_controller_scan_divisor #(
  parameter int unsigned ANCHO = 16
) (
  input  logic             i_Clk,
  input  logic             i_Reset,
  input  logic             i_Habilitar,
  input  logic [ANCHO-1:0] i_Limite,
  output logic             o_Terminal_c
);

  logic [ANCHO-1:0] cuenta;

  assign o_Terminal_c = (cuenta == i_Limite);

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      cuenta <= '0;
    end else if (i_Habilitar) begin
      cuenta <= o_Terminal_c ? '0 : cuenta + ANCHO'(1);
    end
  end

endmodule

// File: rtl/display_scan_controller.sv
// N-digit common-anode scan controller with blanking gaps, frame-aligned
// double-buffered value loads and leading-zero suppression.
module display_scan_controller
  import display_scan_controller_pkg::*;
#(
  parameter int unsigned N_DIGITOS     = 4,
  parameter int unsigned CICLOS_DIGITO = 50000,
  parameter int unsigned CICLOS_BLANCO = 16,
  parameter logic        ANODO_ACTIVO  = 1'b0
) (
  input  logic                              i_Clk,
  input  logic                              i_Reset,
  input  logic [ANCHO_NIBBLE*N_DIGITOS-1:0] i_Valor,
  input  logic                              i_Carga,
  input  logic                              i_Habilitar,
  input  logic                              i_Suprimir_Ceros,
  output logic [ANCHO_NIBBLE-1:0]           o_Digito,
  output logic [N_DIGITOS-1:0]              o_Anodos,
  output logic [2:0]                        o_Indice,
  output logic                              o_Fin_Trama,
  output logic                              o_Pendiente
);

  localparam int unsigned ANCHO_VALOR = ANCHO_NIBBLE * N_DIGITOS;
  localparam int unsigned CICLOS_MAX  = (CICLOS_DIGITO > CICLOS_BLANCO) ? CICLOS_DIGITO : CICLOS_BLANCO;
  localparam int unsigned ANCHO_CNT   = $clog2(CICLOS_MAX);
  localparam logic [2:0]  ULTIMO      = 3'(N_DIGITOS - 1);

  estado_t                estado, estado_sig;
  logic [2:0]             indice, indice_sig;
  logic                   primero;
  logic                   envuelve_c;
  logic                   terminal_c;
  logic [ANCHO_CNT-1:0]   limite_c;
  logic [ANCHO_VALOR-1:0] activo, pendiente_buf;
  logic [N_DIGITOS-1:0]   suprimido_c;
  logic [N_DIGITOS-1:0]   anodos_sig;

  assign limite_c = (estado == ENCENDIDO) ? ANCHO_CNT'(CICLOS_DIGITO - 1)
                                          : ANCHO_CNT'(CICLOS_BLANCO - 1);

  display_scan_controller_scan_divisor #(
    .ANCHO (ANCHO_CNT)
  ) u_divisor (
    .i_Clk        (i_Clk),
    .i_Reset      (i_Reset),
    .i_Habilitar  (i_Habilitar),
    .i_Limite     (limite_c),
    .o_Terminal_c (terminal_c)
  );

  // The blank that follows reset leads into digit 0 without advancing the index.
  always_comb begin
    estado_sig = estado;
    indice_sig = indice;
    envuelve_c = 1'b0;
    if (i_Habilitar && terminal_c) begin
      case (estado)
        ENCENDIDO: estado_sig = BLANCO;
        BLANCO: begin
          estado_sig = ENCENDIDO;
          if (!primero) begin
            if (indice == ULTIMO) begin
              indice_sig = '0;
              envuelve_c = 1'b1;
            end else begin
              indice_sig = indice + 3'd1;
            end
          end
        end
        default: estado_sig = BLANCO;
      endcase
    end
  end

  // A digit above 0 is blank when it and every digit to its left are zero.
  always_comb begin
    suprimido_c = '0;
    for (int k = 1; k < N_DIGITOS; k++) begin
      suprimido_c[k] = i_Suprimir_Ceros && ((activo >> (ANCHO_NIBBLE * k)) == '0);
    end
  end

  always_comb begin
    anodos_sig = {N_DIGITOS{~ANODO_ACTIVO}};
    for (int k = 0; k < N_DIGITOS; k++) begin
      if (i_Habilitar && estado == ENCENDIDO && indice == 3'(k) && !suprimido_c[k]) begin
        anodos_sig[k] = ANODO_ACTIVO;
      end
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      estado        <= BLANCO;
      indice        <= '0;
      primero       <= 1'b1;
      activo        <= '0;
      pendiente_buf <= '0;
      o_Pendiente   <= 1'b0;
      o_Fin_Trama   <= 1'b0;
      o_Anodos      <= {N_DIGITOS{~ANODO_ACTIVO}};
      o_Digito      <= '0;
    end else begin
      estado      <= estado_sig;
      indice      <= indice_sig;
      o_Anodos    <= anodos_sig;
      o_Fin_Trama <= envuelve_c;
      if (estado == BLANCO && estado_sig == ENCENDIDO) begin
        primero <= 1'b0;
      end
      if (estado == ENCENDIDO) begin
        o_Digito <= extraer_digito(ANCHO_MAX'(activo), indice);
      end
      // Old pending value moves to active even if a new load lands on the wrap.
      if (envuelve_c && o_Pendiente) begin
        activo <= pendiente_buf;
      end
      if (i_Carga) begin
        pendiente_buf <= i_Valor;
        o_Pendiente   <= 1'b1;
      end else if (envuelve_c) begin
        o_Pendiente <= 1'b0;
      end
    end
  end

  assign o_Indice = indice;

endmodule

// File: tb/tb_display_scan_controller.sv
// Randomized bench for display_scan_controller against a schedule-position model.
module tb_display_scan_controller;

  localparam int N     = 4;
  localparam int CD    = 4;
  localparam int CB    = 2;
  localparam int PD    = CD + CB;
  localparam int FRAME = N * PD;

  logic        i_Clk = 1'b0;
  logic        i_Reset = 1'b0;
  logic [15:0] i_Valor = '0;
  logic        i_Carga = 1'b0;
  logic        i_Habilitar = 1'b0;
  logic        i_Suprimir_Ceros = 1'b0;
  logic [3:0]  o_Digito;
  logic [3:0]  o_Anodos;
  logic [2:0]  o_Indice;
  logic        o_Fin_Trama;
  logic        o_Pendiente;

  display_scan_controller #(
    .N_DIGITOS     (N),
    .CICLOS_DIGITO (CD),
    .CICLOS_BLANCO (CB),
    .ANODO_ACTIVO  (1'b0)
  ) dut (
    .i_Clk            (i_Clk),
    .i_Reset          (i_Reset),
    .i_Valor          (i_Valor),
    .i_Carga          (i_Carga),
    .i_Habilitar      (i_Habilitar),
    .i_Suprimir_Ceros (i_Suprimir_Ceros),
    .o_Digito         (o_Digito),
    .o_Anodos         (o_Anodos),
    .o_Indice         (o_Indice),
    .o_Fin_Trama      (o_Fin_Trama),
    .o_Pendiente      (o_Pendiente)
  );

  always #5 i_Clk = ~i_Clk;

  // Model: p = enabled cycles since reset; a 2-cycle lead-in blank, then frames.
  int          p;
  logic [15:0] m_act, m_pv;
  bit          m_pend;
  logic [3:0]  exp_an, exp_dig;
  logic [2:0]  exp_idx;
  logic        exp_fin, exp_pend;
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;

  function automatic bit enc_at(int q);
    if (q < CB) return 1'b0;
    return ((q - CB) % PD) < CD;
  endfunction

  function automatic int dig_at(int q);
    if (q < CB) return 0;
    return ((q - CB) % FRAME) / PD;
  endfunction

  function automatic bit next_wraps();
    return i_Habilitar && p >= CB && ((p + 1 - CB) % FRAME) == 0;
  endfunction

  function automatic bit blanked(int d);
    return i_Suprimir_Ceros && d > 0 && ((m_act >> (4 * d)) == 16'h0);
  endfunction

  task automatic tick();
    int d;
    bit wr;
    d  = dig_at(p);
    wr = next_wraps();
    if (i_Reset) begin
      p = 0; m_act = '0; m_pv = '0; m_pend = 1'b0;
      exp_an = 4'hF; exp_dig = '0; exp_idx = '0; exp_fin = 1'b0;
    end else begin
      exp_an = 4'hF;
      if (i_Habilitar && enc_at(p) && !blanked(d)) exp_an[d] = 1'b0;
      if (enc_at(p)) exp_dig = m_act[4*d +: 4];
      exp_fin = wr;
      if (wr && m_pend) m_act = m_pv;
      if (i_Carga) begin
        m_pv = i_Valor; m_pend = 1'b1;
      end else if (wr) begin
        m_pend = 1'b0;
      end
      if (i_Habilitar) p++;
      exp_idx = 3'(dig_at(p));
    end
    exp_pend = m_pend;
    @(posedge i_Clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    i_Reset = 1'b1; i_Habilitar = 1'b0; i_Carga = 1'b0;
    tick();
    i_Reset = 1'b0;
    total += 5;
    if (o_Anodos !== 4'hF) begin bad++; $display("FAIL reset_anodos got=%b exp=1111", o_Anodos); end
    if (o_Digito !== 4'h0) begin bad++; $display("FAIL reset_digito got=%h exp=0", o_Digito); end
    if (o_Indice !== 3'd0) begin bad++; $display("FAIL reset_indice got=%0d exp=0", o_Indice); end
    if (o_Fin_Trama !== 1'b0) begin bad++; $display("FAIL reset_fin got=%b exp=0", o_Fin_Trama); end
    if (o_Pendiente !== 1'b0) begin bad++; $display("FAIL reset_pend got=%b exp=0", o_Pendiente); end
  endtask

  task automatic test_scan();
    int fins = 0;
    int last = -1;
    i_Habilitar = 1'b1;
    for (int i = 0; i < 2 * FRAME + CB; i++) begin
      tick();
      total++;
      if ({o_Anodos, o_Digito, o_Indice, o_Fin_Trama, o_Pendiente} !== {exp_an, exp_dig, exp_idx, exp_fin, exp_pend}) begin
        bad++;
        $display("FAIL scan cyc=%0d got an=%b d=%h i=%0d f=%b p=%b exp an=%b d=%h i=%0d f=%b p=%b",
                 cyc, o_Anodos, o_Digito, o_Indice, o_Fin_Trama, o_Pendiente, exp_an, exp_dig, exp_idx, exp_fin, exp_pend);
      end
      if (o_Fin_Trama === 1'b1) begin
        if (last >= 0) begin
          total++;
          if (cyc - last !== FRAME) begin bad++; $display("FAIL frame_period got=%0d exp=%0d", cyc - last, FRAME); end
        end
        last = cyc;
        fins++;
      end
    end
    total++;
    if (fins !== 2) begin bad++; $display("FAIL frame_pulses got=%0d exp=2", fins); end
  endtask

  task automatic test_load();
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 5 + r * 3; i++) tick();
      i_Valor = (r == 0) ? 16'h1234 : 16'($urandom);
      i_Carga = 1'b1;
      tick();
      i_Carga = 1'b0;
      total++;
      if (o_Pendiente !== 1'b1) begin bad++; $display("FAIL load_pend got=%b exp=1", o_Pendiente); end
      for (int i = 0; i < FRAME + 30; i++) begin
        tick();
        total++;
        if ({o_Anodos, o_Digito, o_Indice, o_Fin_Trama, o_Pendiente} !== {exp_an, exp_dig, exp_idx, exp_fin, exp_pend}) begin
          bad++;
          $display("FAIL load cyc=%0d got an=%b d=%h i=%0d f=%b p=%b exp an=%b d=%h i=%0d f=%b p=%b",
                   cyc, o_Anodos, o_Digito, o_Indice, o_Fin_Trama, o_Pendiente, exp_an, exp_dig, exp_idx, exp_fin, exp_pend);
        end
      end
    end
  endtask

  task automatic test_suppress();
    logic [15:0] vals [4] = '{16'h0050, 16'h0000, 16'h0100, 16'h7000};
    i_Suprimir_Ceros = 1'b1;
    for (int r = 0; r < 6; r++) begin
      i_Valor = (r < 4) ? vals[r] : 16'($urandom_range(0, 16'h00FF));
      i_Carga = 1'b1;
      tick();
      i_Carga = 1'b0;
      for (int i = 0; i < 2 * FRAME; i++) begin
        tick();
        total++;
        if ({o_Anodos, o_Digito, o_Indice, o_Fin_Trama, o_Pendiente} !== {exp_an, exp_dig, exp_idx, exp_fin, exp_pend}) begin
          bad++;
          $display("FAIL suppress cyc=%0d got an=%b d=%h i=%0d f=%b p=%b exp an=%b d=%h i=%0d f=%b p=%b",
                   cyc, o_Anodos, o_Digito, o_Indice, o_Fin_Trama, o_Pendiente, exp_an, exp_dig, exp_idx, exp_fin, exp_pend);
        end
      end
    end
    i_Suprimir_Ceros = 1'b0;
  endtask

  task automatic test_back_to_back();
    bit found = 1'b0;
    i_Valor = 16'hAAAA; i_Carga = 1'b1; tick(); i_Carga = 1'b0;
    tick(); tick();
    i_Valor = 16'hBBBB; i_Carga = 1'b1; tick(); i_Carga = 1'b0;
    for (int i = 0; i < 3 * FRAME && !found; i++) begin
      if (next_wraps()) found = 1'b1;
      else tick();
    end
    total++;
    if (!found) begin
      bad++; $display("FAIL b2b_wrap_timeout got=none exp=wrap");
    end else begin
      i_Valor = 16'hCCCC; i_Carga = 1'b1; tick(); i_Carga = 1'b0;
      total += 2;
      if (o_Fin_Trama !== 1'b1) begin bad++; $display("FAIL b2b_fin got=%b exp=1", o_Fin_Trama); end
      if (o_Pendiente !== 1'b1) begin bad++; $display("FAIL b2b_pend got=%b exp=1", o_Pendiente); end
    end
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick();
      total++;
      if ({o_Anodos, o_Digito, o_Indice, o_Fin_Trama, o_Pendiente} !== {exp_an, exp_dig, exp_idx, exp_fin, exp_pend}) begin
        bad++;
        $display("FAIL b2b cyc=%0d got an=%b d=%h i=%0d f=%b p=%b exp an=%b d=%h i=%0d f=%b p=%b",
                 cyc, o_Anodos, o_Digito, o_Indice, o_Fin_Trama, o_Pendiente, exp_an, exp_dig, exp_idx, exp_fin, exp_pend);
      end
    end
  endtask

  task automatic test_disable();
    bit found = 1'b0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      if (dig_at(p) == 2 && enc_at(p) && ((p - CB) % PD) == 1) found = 1'b1;
      else tick();
    end
    total++;
    if (!found) begin bad++; $display("FAIL disable_timeout got=none exp=digit2"); end
    i_Habilitar = 1'b0;
    for (int i = 0; i < int'($urandom_range(5, 20)); i++) begin
      tick();
      total += 2;
      if (o_Indice !== 3'd2) begin bad++; $display("FAIL disable_indice got=%0d exp=2", o_Indice); end
      if ({o_Anodos, o_Digito, o_Indice, o_Fin_Trama, o_Pendiente} !== {exp_an, exp_dig, exp_idx, exp_fin, exp_pend}) begin
        bad++;
        $display("FAIL disable cyc=%0d got an=%b d=%h i=%0d f=%b p=%b exp an=%b d=%h i=%0d f=%b p=%b",
                 cyc, o_Anodos, o_Digito, o_Indice, o_Fin_Trama, o_Pendiente, exp_an, exp_dig, exp_idx, exp_fin, exp_pend);
      end
    end
    i_Habilitar = 1'b1;
    for (int i = 0; i < FRAME; i++) begin
      tick();
      total++;
      if ({o_Anodos, o_Digito, o_Indice, o_Fin_Trama, o_Pendiente} !== {exp_an, exp_dig, exp_idx, exp_fin, exp_pend}) begin
        bad++;
        $display("FAIL resume cyc=%0d got an=%b d=%h i=%0d f=%b p=%b exp an=%b d=%h i=%0d f=%b p=%b",
                 cyc, o_Anodos, o_Digito, o_Indice, o_Fin_Trama, o_Pendiente, exp_an, exp_dig, exp_idx, exp_fin, exp_pend);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit found = 1'b0;
    i_Valor = 16'h9876; i_Carga = 1'b1; tick(); i_Carga = 1'b0;
    for (int i = 0; i < FRAME && !found; i++) begin
      if (enc_at(p) && ((p - CB) % PD) == 2) found = 1'b1;
      else tick();
    end
    total++;
    if (!found) begin bad++; $display("FAIL rstmid_timeout got=none exp=dwell"); end
    i_Reset = 1'b1; tick(); i_Reset = 1'b0;
    total += 3;
    if (o_Anodos !== 4'hF) begin bad++; $display("FAIL rstmid_anodos got=%b exp=1111", o_Anodos); end
    if (o_Pendiente !== 1'b0) begin bad++; $display("FAIL rstmid_pend got=%b exp=0", o_Pendiente); end
    if (o_Indice !== 3'd0) begin bad++; $display("FAIL rstmid_indice got=%0d exp=0", o_Indice); end
    for (int i = 0; i < FRAME + CB; i++) begin
      tick();
      total++;
      if ({o_Anodos, o_Digito, o_Indice, o_Fin_Trama, o_Pendiente} !== {exp_an, exp_dig, exp_idx, exp_fin, exp_pend}) begin
        bad++;
        $display("FAIL rstmid cyc=%0d got an=%b d=%h i=%0d f=%b p=%b exp an=%b d=%h i=%0d f=%b p=%b",
                 cyc, o_Anodos, o_Digito, o_Indice, o_Fin_Trama, o_Pendiente, exp_an, exp_dig, exp_idx, exp_fin, exp_pend);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      i_Carga          = ($urandom_range(0, 7) == 0);
      i_Valor          = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 16'h0FFF)) : 16'($urandom);
      i_Habilitar      = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 31) == 0) i_Suprimir_Ceros = ~i_Suprimir_Ceros;
      tick();
      total++;
      if ({o_Anodos, o_Digito, o_Indice, o_Fin_Trama, o_Pendiente} !== {exp_an, exp_dig, exp_idx, exp_fin, exp_pend}) begin
        bad++;
        $display("FAIL random cyc=%0d got an=%b d=%h i=%0d f=%b p=%b exp an=%b d=%h i=%0d f=%b p=%b",
                 cyc, o_Anodos, o_Digito, o_Indice, o_Fin_Trama, o_Pendiente, exp_an, exp_dig, exp_idx, exp_fin, exp_pend);
      end
    end
    i_Carga = 1'b0;
  endtask

  initial begin
    test_reset();
    test_scan();
    test_load();
    test_suppress();
    test_back_to_back();
    test_disable();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
